div16_post: RTL

Output stage of the pipelined 16-bit divider. It sits directly downstream of the last divider stage and consumes its 32-bit accumulator (remainder in bits 31:16, quotient in bits 15:0), which are magnitudes only. An internal sideband delay line, aligned to the stage chain, carries each operation's sign and exception flags. The block applies sign correction and the divide-by-zero and signed-overflow overrides, then presents a registered result with a valid pulse to the ALU result mux.

---
 rtl/div16_post.sv | 106 ++++++++++
 1 files changed

// File: rtl/div16_post.sv
// div16_post: output stage of the pipelined 16-bit divider.
// Sign correction, divide-by-zero / overflow override, registered result.
module div16_post #(
    parameter int STAGES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_signed,
    input  logic [15:0] in_dividend,
    input  logic [15:0] in_divisor,
    input  logic [31:0] acc_in,
    output logic        out_valid,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_zero,
    output logic        overflow
);

    typedef struct packed {
        logic        v;
        logic        dz;
        logic        ov;
        logic        neg_q;
        logic        neg_r;
        logic [15:0] dvd;
    } side_t;

    side_t       w_head;
    side_t       w_tail;
    side_t       r_line [0:STAGES];
    logic [15:0] w_q_mag;
    logic [15:0] w_r_mag;
    logic [15:0] w_q;
    logic [15:0] w_r;

    // Issue-cycle decode of the raw operands into sideband flags
    always_comb begin
        w_head.v     = in_valid;
        w_head.dz    = (in_divisor == 16'h0000);
        w_head.ov    = in_signed
                     & (in_dividend == 16'h8000)
                     & (in_divisor == 16'hFFFF);
        w_head.neg_q = in_signed & (in_dividend[15] ^ in_divisor[15]);
        w_head.neg_r = in_signed & in_dividend[15];
        w_head.dvd   = in_dividend;
    end

    // Sideband delay line; slot STAGES lines up with acc_in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= STAGES; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_line[0] <= w_head;
            for (int i = 1; i <= STAGES; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign w_tail  = r_line[STAGES];
    assign w_q_mag = acc_in[15:0];
    assign w_r_mag = acc_in[31:16];

    // Result select: exceptions override the chain's magnitudes
    always_comb begin
        w_q = w_q_mag;
        w_r = w_r_mag;
        unique case (1'b1)
            w_tail.dz: begin
                w_q = 16'hFFFF;
                w_r = w_tail.dvd;
            end
            w_tail.ov: begin
                w_q = 16'h8000;
                w_r = 16'h0000;
            end
            default: begin
                w_q = w_tail.neg_q ? (~w_q_mag + 16'd1) : w_q_mag;
                w_r = w_tail.neg_r ? (~w_r_mag + 16'd1) : w_r_mag;
            end
        endcase
    end

    // Registered result; data holds between retirements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            quotient  <= 16'h0000;
            remainder <= 16'h0000;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= w_tail.v;
            if (w_tail.v) begin
                quotient  <= w_q;
                remainder <= w_r;
                div_zero  <= w_tail.dz;
                overflow  <= w_tail.ov & ~w_tail.dz;
            end
        end
    end

endmodule
